// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one byte-addressed RAM between instruction-fetch and load/store ports.
// Latency: grant edge -> ACCESS -> RESP; 3 cycles minimum, plus one per RAM wait cycle (timeout bounded).
// Backpressure: each requester is held by its waitrequest until a single RESP cycle; RAM stalls via mem_waitrequest.
module mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       i_readdata,
    output logic              i_waitrequest,
    output logic              i_err,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [3:0]        d_byteenable,
    input  logic [31:0]       d_writedata,
    output logic [31:0]       d_readdata,
    output logic              d_waitrequest,
    output logic              d_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_waitrequest
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;   // 1 = data port won the previous grant
    logic              win_q, win_d;     // 1 = data port owns the current access
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic              i_err_q, i_err_d, d_err_q, d_err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              req_i, req_d, grant_d;
    logic              resp_load, resp_err;
    logic [31:0]       resp_data;

    assign req_i   = i_read;
    assign req_d   = d_read | d_write;
    assign grant_d = req_d & (~req_i | ~last_q);

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        win_d     = win_q;
        addr_d    = addr_q;
        wr_d      = wr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_err_d   = i_err_q;
        d_err_d   = d_err_q;
        resp_load = 1'b0;
        resp_err  = 1'b0;
        resp_data = 32'h0;

        case (state_q)
            IDLE: begin
                if (req_i | req_d) begin
                    win_d   = grant_d;
                    last_d  = grant_d;
                    addr_d  = grant_d ? d_addr : i_addr;
                    wr_d    = grant_d & d_write;
                    be_d    = grant_d ? d_byteenable : 4'b1111;
                    wdata_d = grant_d ? d_writedata : wdata_q;
                    if (addr_d[1:0] != 2'b00) begin
                        // Misaligned: answer with an error without touching the RAM
                        state_d   = RESP;
                        resp_load = 1'b1;
                        resp_err  = 1'b1;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (!mem_waitrequest) begin
                    state_d   = RESP;
                    cnt_d     = '0;
                    resp_load = 1'b1;
                    resp_data = wr_q ? 32'h0 : mem_readdata;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                    state_d   = RESP;
                    cnt_d     = '0;
                    resp_load = 1'b1;
                    resp_err  = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (resp_load) begin
            if (win_d) begin
                d_rdata_d = resp_data;
                d_err_d   = resp_err;
            end else begin
                i_rdata_d = resp_data;
                i_err_d   = resp_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= 1'b0;
            win_q     <= 1'b0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            be_q      <= 4'b0000;
            wdata_q   <= 32'h0;
            cnt_q     <= '0;
            i_rdata_q <= 32'h0;
            d_rdata_q <= 32'h0;
            i_err_q   <= 1'b0;
            d_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            win_q     <= win_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_err_q   <= i_err_d;
            d_err_q   <= d_err_d;
        end
    end

    // Strobes and waitrequests decode registered state only
    assign mem_read       = (state_q == ACCESS) & ~wr_q;
    assign mem_write      = (state_q == ACCESS) &  wr_q;
    assign mem_address    = addr_q;
    assign mem_byteenable = be_q;
    assign mem_writedata  = wdata_q;

    assign i_waitrequest  = ~((state_q == RESP) & ~win_q);
    assign d_waitrequest  = ~((state_q == RESP) &  win_q);
    assign i_readdata     = i_rdata_q;
    assign d_readdata     = d_rdata_q;
    assign i_err          = i_err_q;
    assign d_err          = d_err_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and access sequencer that shares the single byte-addressed data RAM between the instruction-fetch port and the load/store data port of the MIPS CPU. Each requester uses a waitrequest handshake. The arbiter grants one access at a time with round-robin fairness and drives the RAM-side strobes from registered state. Misaligned accesses are rejected, and stalled RAM accesses are aborted with an error.

## Interface
Parameters:
- ADDR_W, 32, byte-address width on all ports
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles with mem_waitrequest high before abort; 0 disables the timeout

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- i_read  in  1  instruction-port read request; held until i_waitrequest low
- i_addr  in  ADDR_W  instruction byte address
- i_readdata  out  32  instruction data; valid while i_waitrequest low
- i_waitrequest  out  1  low for exactly the one completion cycle
- i_err  out  1  error flag; valid with the completion cycle
- d_read, d_write  in  1  data-port strobes; mutually exclusive; held until d_waitrequest low
- d_addr  in  ADDR_W  data byte address
- d_byteenable  in  4  lane enables; bit n covers bits [8n+7:8n]
- d_writedata  in  32  store data
- d_readdata  out  32  load data; valid while d_waitrequest low
- d_waitrequest  out  1  as i_waitrequest
- d_err  out  1  as i_err
- mem_address  out  ADDR_W  RAM byte address
- mem_read, mem_write  out  1  RAM strobes
- mem_byteenable  out  4  RAM lane enables
- mem_writedata  out  32  RAM store data
- mem_readdata  in  32  RAM load data; sampled when mem_waitrequest is low
- mem_waitrequest  in  1  RAM stall

## Operation
- States: IDLE, ACCESS, RESP. The block also holds a one-bit last-grant pointer `last`.
- IDLE:
  - Samples i_read, d_read and d_write at each edge.
  - If no request is present, the FSM stays in IDLE.
  - If exactly one port requests, that port wins.
  - If both request, the port that did not win last time wins.
- On a grant, the block registers addr, rw, byteenable, writedata and the winner, and updates `last`.
  - The instruction port is read-only; its byteenable is forced to 4'b1111.
- Aligned grant (addr[1:0]==0) goes to ACCESS. Misaligned grant goes directly to RESP with err=1 and readdata=0, and no RAM access is issued.
- ACCESS:
  - mem_read or mem_write is asserted from the registered rw. mem_address, mem_byteenable and mem_writedata come from the registered values.
  - At an edge where mem_waitrequest==0, the block latches mem_readdata (reads) or 0 (writes) into the winner's readdata register. It then goes to RESP with err=0.
  - A timeout counter increments each ACCESS cycle while mem_waitrequest==1. When the count reaches TIMEOUT_CYCLES, the strobes drop, readdata is set to 0, err=1, and the FSM goes to RESP.
- RESP: the winner's waitrequest is 0 for exactly one cycle with readdata and err stable. The FSM returns to IDLE. The loser's waitrequest stays 1.
- The RAM strobes are low outside ACCESS. mem_address, mem_byteenable and mem_writedata hold their last values.
- The counter is 0 outside ACCESS and saturates at TIMEOUT_CYCLES.
- If a master drops its request while in ACCESS (protocol violation), the access still completes and the response is discarded.

## Timing
- Reset (async assert, sync release) forces:
  - state=IDLE, last=instruction, so the data port wins the first contention
  - mem_read=mem_write=0, mem_address=0, mem_byteenable=0, mem_writedata=0
  - i_waitrequest=d_waitrequest=1
  - i_readdata=d_readdata=0, i_err=d_err=0
- Reset mid-ACCESS drops the strobes immediately (asynchronously). The in-flight access is abandoned with no response.
- Minimum latency when the RAM has zero wait: request asserted in cycle 0, ACCESS in cycle 1, RESP (waitrequest low) in cycle 2, IDLE in cycle 3. Peak throughput is one access per 3 cycles.
- Each RAM wait cycle adds one cycle.
- A timeout response appears in the RESP cycle following the TIMEOUT_CYCLES-th stalled ACCESS cycle.
- The request sampled in IDLE is the value present during the IDLE cycle. A master that dropped its request after RESP is not re-granted.
- Upstream waitrequest is a registered-state decode with no combinational path from the request inputs.

## Test plan
- Single read: d_read, d_addr=0x10, mem_readdata=0xDEADBEEF, no wait -> mem_read high in cycle 1 only; d_waitrequest low in cycle 2 with d_readdata=0xDEADBEEF and d_err=0.
- Contention: i_read and d_write asserted together from reset, held -> data granted first (mem_write in cycle 1), instruction granted next (mem_read in cycle 4). Repeated contention alternates grants.
- Byte store: d_write, addr=0x20, be=4'b0100, wdata=0x00AB0000 -> mem_byteenable=4'b0100 and mem_writedata=0x00AB0000 during ACCESS.
- Misaligned: d_read, addr=0x13 -> no mem_read pulse; d_waitrequest low one cycle after the grant edge with d_err=1 and d_readdata=0.
- Timeout: TIMEOUT_CYCLES=4, mem_waitrequest held 1 -> mem_read high for exactly 4 cycles; then RESP with err=1. With TIMEOUT_CYCLES=0 the access stalls indefinitely.
- Reset mid-access: rst_n low during ACCESS -> mem_read drops with no clock edge. After release, the block is in IDLE with both waitrequests at 1, and a pending i_read is granted normally.
